// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 active-low matrix keypad scanner with per-key frame debounce and event FIFO.
// Define KEYPAD_RELEASE_EVT_EN to queue release events as well as press events.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC      = 16,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  col_in,
    output logic [3:0]  row,
    output logic [15:0] key_state,
    output logic        evt_valid,
    output logic [4:0]  evt_data,
    input  logic        evt_pop,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic        irq
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]       DEB_TGT     = 4'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, EMIT} state_t;

    state_t     state, state_n;
    logic [1:0] row_idx, row_idx_n;
    logic [7:0] settle_cnt, settle_n;
    logic [3:0] emit_idx, emit_n;
    logic       sample_en, emit_en;

    logic [3:0]  col_s1, col_s2;
    logic [15:0] raw;
    logic [3:0]  deb_cnt  [16];
    logic [3:0]  cnt_inc  [16];
    logic [3:0]  cnt_next [16];
    logic [15:0] flip;
    logic [15:0] changed;

    logic [4:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             evt_changed, evt_new_state, push_req, push_ok, pop_ok, fifo_full, drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row_idx    <= 2'd0;
            settle_cnt <= 8'd0;
            emit_idx   <= 4'd0;
        end else begin
            state      <= state_n;
            row_idx    <= row_idx_n;
            settle_cnt <= settle_n;
            emit_idx   <= emit_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_idx_n = row_idx;
        settle_n  = settle_cnt;
        emit_n    = emit_idx;
        sample_en = 1'b0;
        emit_en   = 1'b0;
        row       = 4'hF;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n   = DRIVE;
                    row_idx_n = 2'd0;
                    settle_n  = 8'd0;
                end
            end
            DRIVE: begin
                row = ~(4'b0001 << row_idx);
                if (!enable) begin
                    state_n = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            SAMPLE: begin
                row       = ~(4'b0001 << row_idx);
                sample_en = 1'b1;
                settle_n  = 8'd0;
                if (!enable) begin
                    state_n = IDLE;
                end else if (row_idx == 2'd3) begin
                    state_n = EMIT;
                    emit_n  = 4'd0;
                end else begin
                    state_n   = DRIVE;
                    row_idx_n = row_idx + 2'd1;
                end
            end
            EMIT: begin
                emit_en = 1'b1;
                if (emit_idx == 4'd15) begin
                    if (enable) begin
                        state_n   = DRIVE;
                        row_idx_n = 2'd0;
                        settle_n  = 8'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    emit_n = emit_idx + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_s1 <= 4'hF;
            col_s2 <= 4'hF;
            raw    <= 16'h0000;
        end else begin
            col_s1 <= col_in;
            col_s2 <= col_s1;
            if (sample_en) begin
                raw[row_idx*4 +: 4] <= ~col_s2;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            cnt_inc[k]  = deb_cnt[k] + 4'd1;
            flip[k]     = (raw[k] != key_state[k]) && (cnt_inc[k] == DEB_TGT);
            cnt_next[k] = cnt_inc[k];
            if ((raw[k] == key_state[k]) || flip[k]) begin
                cnt_next[k] = 4'd0;
            end
        end
    end

    // Debounce runs once per frame, on the first EMIT cycle; later EMIT cycles read the stored change flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_state <= 16'h0000;
            changed   <= 16'h0000;
            for (int k = 0; k < 16; k++) begin
                deb_cnt[k] <= 4'd0;
            end
        end else if (emit_en && (emit_idx == 4'd0)) begin
            key_state <= key_state ^ flip;
            changed   <= flip;
            for (int k = 0; k < 16; k++) begin
                deb_cnt[k] <= cnt_next[k];
            end
        end
    end

    always_comb begin
        evt_changed   = (emit_idx == 4'd0) ? flip[0] : changed[emit_idx];
        evt_new_state = (emit_idx == 4'd0) ? (key_state[0] ^ flip[0]) : key_state[emit_idx];
`ifdef KEYPAD_RELEASE_EVT_EN
        push_req = emit_en && evt_changed;
`else
        push_req = emit_en && evt_changed && evt_new_state;
`endif
        pop_ok    = evt_pop && (count != '0);
        fifo_full = (count == FULL_CNT);
        push_ok   = push_req && (!fifo_full || pop_ok);
        drop      = push_req && fifo_full && !pop_ok;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {evt_new_state, emit_idx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            irq <= evt_valid | overflow;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : 5'd0;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: keypad matrix model, frame-level reference model with
// per-cycle compare, directed literal scenarios and a randomized key/pop phase.
module tb_keypad_scan_ctrl;
    localparam int S        = 16;
    localparam int DF       = 4;
    localparam int DEPTH    = 8;
    localparam int ROW_SPAN = S + 1;
    localparam int E        = 4 * ROW_SPAN;
    localparam int FRAME    = E + 16;
`ifdef KEYPAD_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, evt_pop, ovf_clr, col_force;
    logic [3:0]  col_in, row;
    logic [15:0] key_state, pressed;
    logic        evt_valid, overflow, irq;
    logic [4:0]  evt_data;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;
    bit stop_pop = 1'b0;

    int          mpos;
    logic [4:0]  mq[$];
    logic [15:0] mks, mraw, mchg;
    int          mcnt[16];
    bit          movf, mirq;

    keypad_scan_ctrl #(.SETTLE_CYC(S), .DEBOUNCE_FRAMES(DF), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .col_in(col_in), .row(row),
        .key_state(key_state), .evt_valid(evt_valid), .evt_data(evt_data),
        .evt_pop(evt_pop), .overflow(overflow), .ovf_clr(ovf_clr), .irq(irq)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && pressed[r*4+c]) col_in[c] = 1'b0;
            end
        end
        if (col_force) col_in = 4'h0;
    end

    // Reference model: frame position counter, per-key debounce and an event queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mpos = -1;
            mq.delete();
            mks  = '0;
            mraw = '0;
            mchg = '0;
            movf = 1'b0;
            mirq = 1'b0;
            for (int k = 0; k < 16; k++) mcnt[k] = 0;
        end else begin
            int  sz;
            bit  pop_ok, set_ovf;
            sz      = mq.size();
            pop_ok  = evt_pop && (sz > 0);
            set_ovf = 1'b0;
            mirq    = (sz > 0) || movf;
            if (mpos == E) begin
                for (int k = 0; k < 16; k++) begin
                    mchg[k] = 1'b0;
                    if (mraw[k] != mks[k]) begin
                        mcnt[k]++;
                        if (mcnt[k] == DF) begin
                            mks[k]  = ~mks[k];
                            mcnt[k] = 0;
                            mchg[k] = 1'b1;
                        end
                    end else begin
                        mcnt[k] = 0;
                    end
                end
            end
            if (pop_ok) void'(mq.pop_front());
            if (mpos >= E) begin
                int i;
                i = mpos - E;
                if (mchg[i] && (REL_EN || mks[i])) begin
                    if (sz < DEPTH || pop_ok) mq.push_back({mks[i], 4'(i)});
                    else set_ovf = 1'b1;
                end
            end
            if (set_ovf) movf = 1'b1;
            else if (ovf_clr) movf = 1'b0;
            if (mpos >= 0 && mpos < E && (mpos % ROW_SPAN) == S) begin
                int r;
                r = mpos / ROW_SPAN;
                mraw[r*4 +: 4] = pressed[r*4 +: 4];
            end
            if (mpos < 0) begin
                if (enable) mpos = 0;
            end else if (mpos < E && !enable) begin
                mpos = -1;
            end else if (mpos == FRAME - 1) begin
                mpos = enable ? 0 : -1;
            end else begin
                mpos++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) begin
            logic [3:0] er;
            er = 4'hF;
            if (mpos >= 0 && mpos < E) er[mpos / ROW_SPAN] = 1'b0;
            checkOutput("model_row", row, er);
            checkOutput("model_key_state", key_state, mks);
            checkOutput("model_evt_valid", evt_valid, mq.size() > 0);
            if (mq.size() > 0) checkOutput("model_evt_data", evt_data, mq[0]);
            checkOutput("model_overflow", overflow, movf);
            checkOutput("model_irq", irq, mirq);
        end
    end

    task automatic waitPos(input int target);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mpos != target && n < 3 * FRAME);
        if (mpos != target) checkOutput("wait_timeout", mpos, target);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int frames);
        pressed = keys;
        repeat (frames) waitPos(E + 1);
    endtask

    task automatic popOne();
        evt_pop = 1'b1;
        @(negedge clk);
        evt_pop = 1'b0;
    endtask

    task automatic drainFifo();
        for (int n = 0; n < 40 && evt_valid; n++) popOne();
    endtask

    task automatic clearOverflow();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    logic [4:0] ovf_list [8];

    initial begin
        ovf_list = '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h19};
        rst = 1'b1; enable = 1'b0; evt_pop = 1'b0; ovf_clr = 1'b0; col_force = 1'b0; pressed = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_row", row, 4'hF);
        checkOutput("rst_key_state", key_state, 16'h0);
        checkOutput("rst_evt_valid", evt_valid, 1'b0);
        checkOutput("rst_evt_data", evt_data, 5'h0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_irq", irq, 1'b0);
        #2 rst = 1'b0;
        check_en = 1'b1;

        // Key 6 held: sets at frame 4, one press event, irq one cycle behind evt_valid.
        pressed = 16'h0040;
        enable  = 1'b1;
        applyStimulus(16'h0040, 3);
        checkOutput("k6_ks_f3", key_state, 16'h0000);
        waitPos(E + 1);
        checkOutput("k6_ks_f4", key_state, 16'h0040);
        waitPos(E + 6);
        checkOutput("k6_valid_pre", evt_valid, 1'b0);
        waitPos(E + 7);
        checkOutput("k6_valid", evt_valid, 1'b1);
        checkOutput("k6_data", evt_data, 5'h16);
        checkOutput("k6_irq_lag", irq, 1'b0);
        waitPos(E + 8);
        checkOutput("k6_irq", irq, 1'b1);
        applyStimulus(16'h0040, 1);
        checkOutput("k6_ks_f5", key_state, 16'h0040);
        checkOutput("k6_data_f5", evt_data, 5'h16);
        popOne();
        checkOutput("k6_popped", evt_valid, 1'b0);
        applyStimulus(16'h0000, 3);
        checkOutput("k6_rel_f3", key_state, 16'h0040);
        applyStimulus(16'h0000, 1);
        checkOutput("k6_rel_f4", key_state, 16'h0000);
        waitPos(E + 7);
`ifdef KEYPAD_RELEASE_EVT_EN
        checkOutput("k6_rel_evt", evt_data, 5'h06);
`else
        checkOutput("k6_rel_noevt", evt_valid, 1'b0);
`endif
        drainFifo();

        // Key 3 glitches of 1 and 3 frames are filtered, 4 frames register.
        waitPos(E + 1);
        applyStimulus(16'h0008, 1);
        applyStimulus(16'h0000, 1);
        checkOutput("k3_1f_ks", key_state, 16'h0000);
        checkOutput("k3_1f_valid", evt_valid, 1'b0);
        applyStimulus(16'h0008, 3);
        applyStimulus(16'h0000, 1);
        checkOutput("k3_3f_ks", key_state, 16'h0000);
        checkOutput("k3_3f_valid", evt_valid, 1'b0);
        applyStimulus(16'h0008, 4);
        waitPos(E + 5);
        checkOutput("k3_4f_valid", evt_valid, 1'b1);
        checkOutput("k3_4f_data", evt_data, 5'h13);
        checkOutput("k3_4f_ks", key_state, 16'h0008);
        drainFifo();
        applyStimulus(16'h0000, 5);
        drainFifo();

        // Keys 9 and 2 in the same frame: ascending key order.
        waitPos(E + 1);
        applyStimulus(16'h0204, 4);
        waitPos(E + 15);
        checkOutput("k92_first", evt_data, 5'h12);
        popOne();
        checkOutput("k92_second", evt_data, 5'h19);
        popOne();
        checkOutput("k92_empty", evt_valid, 1'b0);
        waitPos(E + 1);
        applyStimulus(16'h0000, 5);
        drainFifo();

        // Ten presses with no pops, then a pop colliding with the last push on a full FIFO.
        waitPos(E + 1);
        applyStimulus(16'h03FF, 4);
        waitPos(E + 9);
        checkOutput("ovf_set", overflow, 1'b1);
        checkOutput("ovf_head", evt_data, 5'h10);
        popOne();
        checkOutput("ovf_head_adv", evt_data, 5'h11);
        waitPos(E + 15);
        checkOutput("ovf_ks", key_state, 16'h03FF);
        for (int i = 0; i < 8; i++) begin
            checkOutput("ovf_drain_valid", evt_valid, 1'b1);
            checkOutput("ovf_drain_data", evt_data, ovf_list[i]);
            popOne();
        end
        checkOutput("ovf_drain_empty", evt_valid, 1'b0);
        checkOutput("ovf_still_set", overflow, 1'b1);
        clearOverflow();
        checkOutput("ovf_cleared", overflow, 1'b0);
        @(negedge clk);
        checkOutput("ovf_irq_clear", irq, 1'b0);

        // Reset in the middle of a row drive with all columns pulled low.
        waitPos(10);
        col_force = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        checkOutput("mrst_row", row, 4'hF);
        checkOutput("mrst_key_state", key_state, 16'h0);
        checkOutput("mrst_evt_valid", evt_valid, 1'b0);
        checkOutput("mrst_evt_data", evt_data, 5'h0);
        checkOutput("mrst_overflow", overflow, 1'b0);
        checkOutput("mrst_irq", irq, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mrst_row_idle", row, 4'hF);
        col_force = 1'b0;

        // Dropping enable during row 2 drive returns to idle; re-enable restarts at row 0.
        pressed = 16'h0040;
        enable  = 1'b1;
        applyStimulus(16'h0040, 4);
        waitPos(2 * ROW_SPAN + 5);
        enable = 1'b0;
        @(negedge clk);
        checkOutput("endrop_row", row, 4'hF);
        checkOutput("endrop_ks", key_state, 16'h0040);
        repeat (3) @(negedge clk);
        checkOutput("endrop_row_hold", row, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("endrop_restart_row", row, 4'b1110);
        waitPos(E + 1);
        drainFifo();

        // Randomized keys, hold lengths, enable drops, pops and overflow clears.
        fork
            begin
                for (int it = 0; it < 40; it++) begin
                    int frames;
                    pressed = 16'($urandom & $urandom & $urandom);
                    frames  = $urandom_range(1, 6);
                    for (int f = 0; f < frames; f++) begin
                        if ($urandom_range(0, 7) == 0) begin
                            waitPos($urandom_range(0, E - 1));
                            enable = 1'b0;
                            repeat ($urandom_range(1, 4)) @(negedge clk);
                            enable = 1'b1;
                        end
                        waitPos(E + 1);
                    end
                end
                stop_pop = 1'b1;
            end
            begin
                while (!stop_pop) begin
                    @(negedge clk);
                    evt_pop = ($urandom_range(0, 3) == 0);
                    ovf_clr = ($urandom_range(0, 31) == 0);
                end
                evt_pop = 1'b0;
                ovf_clr = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad on the APB keyboard peripheral. Drives the active-low rows one at a time, samples the active-low columns after a settle delay, and debounces each of the 16 keys across whole scan frames. Debounced press and release changes are queued as events in a small FIFO that the APB wrapper pops. An interrupt is raised while events or an overflow are pending.

## Interface
- SETTLE_CYC, 16: cycles the row is driven before columns are sampled (≥2, ≤255)
- DEBOUNCE_FRAMES, 4: consecutive differing frames needed to flip a key's debounced state (1..15)
- FIFO_DEPTH, 8: event FIFO entries, power of two (2..32)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- enable  in  1  scan enable
- col_in  in  4  keypad columns, active-low, asynchronous, 2-flop synchronised internally
- row  out  4  keypad rows, active-low one-hot while scanning, 4'hF otherwise
- key_state  out  16  debounced state, bit k = key (row*4+col), 1 = pressed
- evt_valid  out  1  FIFO non-empty
- evt_data  out  5  head event: [4] 1=press/0=release, [3:0] key index
- evt_pop  in  1  pop head event; ignored when empty
- overflow  out  1  sticky: an event was dropped on a full FIFO
- ovf_clr  in  1  clears overflow
- irq  out  1  registered evt_valid | overflow

## Operation
- FSM states: IDLE, DRIVE, SAMPLE, EMIT.
- IDLE: row=4'hF. Go to DRIVE, row 0, when enable=1.
- DRIVE: row r driven low; settle counter runs SETTLE_CYC cycles, then SAMPLE.
- SAMPLE (1 cycle): latch ~synchronised col_in into raw[r*4+3:r*4]. For r<3, go to DRIVE r+1. For r=3, go to EMIT.
- Per-key debounce counter (4 bits), updated on the first EMIT cycle:
  - If raw[k] != key_state[k], increment the counter.
  - If raw[k] == key_state[k], clear the counter.
  - When the count reaches DEBOUNCE_FRAMES, toggle key_state[k], clear the counter, and mark key k changed.
- EMIT (16 cycles, index i=0..15): if key i is changed, push {key_state[i], i}. Events are emitted in ascending key order. Then go to DRIVE row 0, or to IDLE if enable=0.
- enable=0 during DRIVE/SAMPLE: go to IDLE at the next edge and discard the partial frame. key_state, counters and FIFO are kept. EMIT always completes.
- Push while full: event dropped and overflow set. key_state is still updated. A push and pop on the same cycle while full: both occur, count unchanged.
- ovf_clr and an overflow set on the same cycle: set wins.

## Timing
- Reset values:
  - row=4'hF, key_state=0, evt_valid=0, evt_data=0, overflow=0, irq=0.
  - FSM in IDLE, counters 0, FIFO empty.
- Frame length: 4*(SETTLE_CYC+1)+16 cycles (84 at defaults).
- Column path latency: 2 sync flops; SETTLE_CYC≥2 guarantees the sample reflects the current row.
- Push at EMIT cycle i: evt_valid/evt_data update at the next edge. irq follows one cycle later.
- Pop: head advances at the edge on which evt_pop=1; evt_data shows the new head the same cycle.
- Steady press from a clean start: key_state sets at EMIT of frame DEBOUNCE_FRAMES.
- A single-frame glitch never changes key_state.

## Configuration
- KEYPAD_RELEASE_EVT_EN defined: both press and release events are queued.
- Undefined: only press events are queued. Releases still update key_state silently, never set overflow, and evt_data[4] is always 1.

## Test plan
- Reset mid-DRIVE with col_in=0 → all outputs at reset values, row=4'hF until enable and reset release.
- Hold key 6 (row1, col2) for 5 frames at defaults → key_state=16'h0040 after frame 4, one event 5'h16, irq one cycle after evt_valid. With the macro, releasing the key gives event 5'h06 four frames after release.
- Key 3 low for exactly 1 frame, 3 frames, then 4 frames → no event for 1 or 3 frames, one event for 4 frames.
- Keys 9 and 2 pressed in the same frame → events 5'h12 then 5'h19, in that order.
- 10 presses with no pops (FIFO_DEPTH=8) → 8 events held, overflow=1, key_state correct. Pop on a full FIFO while a push arrives keeps count at 8. ovf_clr → overflow=0.
- Drop enable during row 2 DRIVE → row=4'hF next cycle, FSM IDLE, key_state unchanged. Re-enable → scan restarts at row 0.
